// File: rtl/ext_irq_ctrl.sv
// ext_irq_ctrl: external interrupt front-end.
// Each raw line passes through a 2-flop synchronizer and an edge detector.
// Detected events latch into per-source pending bits. A round-robin arbiter
// picks among enabled pending sources and presents them to the core one at
// a time over a req/ack handshake.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   irq_in   raw external interrupt lines (asynchronous to clk)
//   irq_en   per-source arbitration enable
//   irq_ack  core acknowledge of the presented irq_id
//   irq_req  request to core (registered)
//   irq_id   index of the requesting source, valid while irq_req=1
//   pending  per-source pending bits (registered)
//   overrun  sticky per-source flag: edge arrived while already pending
//
// Build option: define IRQ_CTRL_BOTH_EDGE_EN to make both rising and falling
// edges raise events. Without it, only rising edges are detected.
module ext_irq_ctrl #(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_in,
  input  logic [N_SRC-1:0] irq_en,
  input  logic             irq_ack,
  output logic             irq_req,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] overrun
);

  localparam int unsigned IDX_W = ID_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [N_SRC-1:0]   s1;
  logic [N_SRC-1:0]   s2;
  logic [N_SRC-1:0]   s3;
  logic [N_SRC-1:0]   evt;
  logic [N_SRC-1:0]   cand;
  logic [N_SRC-1:0]   clr_mask;
  logic [ID_W-1:0]    rr;
  logic [ID_W-1:0]    win_id;
  logic [IDX_W-1:0]   idx;
  logic               win_found;
  logic               load_id_c;
  logic               take_ack_c;

  // Synchronizer plus history flop for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= irq_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

`ifdef IRQ_CTRL_BOTH_EDGE_EN
  assign evt = s2 ^ s3;
`else
  assign evt = s2 & ~s3;
`endif

  assign cand = pending & irq_en;

  // Round-robin search starting at rr, wrapping modulo N_SRC
  always_comb begin
    win_id    = '0;
    win_found = 1'b0;
    idx       = '0;
    for (int unsigned off = 0; off < N_SRC; off++) begin
      idx = {1'b0, rr} + IDX_W'(off);
      if (idx >= IDX_W'(N_SRC)) begin
        idx = idx - IDX_W'(N_SRC);
      end
      if (!win_found && cand[idx[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = idx[ID_W-1:0];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (win_found) state_next = ST_REQ;
      ST_REQ:  if (irq_ack)   state_next = ST_WAIT;
      ST_WAIT: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM output decode: when to latch a winner, when an ack is honoured
  always_comb begin
    load_id_c  = 1'b0;
    take_ack_c = 1'b0;
    case (state)
      ST_IDLE: load_id_c  = win_found;
      ST_REQ:  take_ack_c = irq_ack;
      default: ;
    endcase
  end

  assign clr_mask = take_ack_c ? (N_SRC'(1) << irq_id) : '0;

  // Request/id registers and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_req <= 1'b0;
      irq_id  <= '0;
      rr      <= '0;
    end else begin
      irq_req <= (state_next == ST_REQ);
      if (load_id_c) begin
        irq_id <= win_id;
      end
      if (take_ack_c) begin
        rr <= (irq_id == ID_W'(N_SRC - 1)) ? '0 : irq_id + ID_W'(1);
      end
    end
  end

  // Pending and overrun: a same-cycle event beats the ack clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      overrun <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | evt;
      overrun <= overrun | (evt & pending & ~clr_mask);
    end
  end

endmodule

// File: tb/tb_ext_irq_ctrl.sv
module tb_ext_irq_ctrl;

  localparam int unsigned N_SRC = 4;
  localparam int unsigned ID_W  = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_SRC-1:0] irq_in;
  logic [N_SRC-1:0] irq_en;
  logic             irq_ack;
  logic             irq_req;
  logic [ID_W-1:0]  irq_id;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] overrun;

  int passed = 0;
  int total  = 0;
  int req_cnt;
  int exp_cnt;

  always #5 clk = ~clk;

  ext_irq_ctrl #(.N_SRC(N_SRC), .ID_W(ID_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .irq_in  (irq_in),
    .irq_en  (irq_en),
    .irq_ack (irq_ack),
    .irq_req (irq_req),
    .irq_id  (irq_id),
    .pending (pending),
    .overrun (overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Bounded wait for a request, then check id and acknowledge it
  task automatic serve(input string tag, input logic [ID_W-1:0] exp_id);
    for (int i = 0; i < 8 && !irq_req; i++) tick();
    chk({tag, "_req"}, 32'(irq_req), 32'd1);
    chk({tag, "_id"}, 32'(irq_id), 32'(exp_id));
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk({tag, "_drop"}, 32'(irq_req), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; irq_in = '0; irq_en = '0; irq_ack = 1'b0;
    tick(); tick();
    chk("rst_req", 32'(irq_req), 32'd0);
    chk("rst_id", 32'(irq_id), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    #2 rst = 1'b0;

    // Single source latency and ack
    irq_en = 4'b0001; irq_in = 4'b0001;
    tick(); tick();
    chk("single_pend_early", 32'(pending), 32'h0);
    tick();
    chk("single_pend", 32'(pending), 32'h1);
    chk("single_req_early", 32'(irq_req), 32'd0);
    irq_in = 4'b0000;
    tick();
    chk("single_req", 32'(irq_req), 32'd1);
    chk("single_id", 32'(irq_id), 32'd0);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("single_clr", 32'(pending), 32'h0);
    chk("single_drop", 32'(irq_req), 32'd0);
    tick();
    chk("single_gap1", 32'(irq_req), 32'd0);
    tick();
    chk("single_gap2", 32'(irq_req), 32'd0);

    // Round-robin from rr=0
    rst = 1'b1; tick(); rst = 1'b0;
    irq_en = 4'b1111; irq_in = 4'b1111;
    tick(); tick(); tick();
    chk("rr_pend", 32'(pending), 32'hf);
    serve("rr0", 2'd0);
    serve("rr1", 2'd1);
    serve("rr2", 2'd2);
    serve("rr3", 2'd3);
    chk("rr_pend_empty", 32'(pending), 32'h0);
    irq_in = 4'b0000;
    tick(); tick(); tick();
    irq_in = 4'b0101;
    tick(); tick(); tick();
    chk("rr2_pend", 32'(pending), 32'h5);
    irq_in = 4'b0000;
    serve("rr2_0", 2'd0);
    serve("rr2_2", 2'd2);
    chk("rr2_pend_empty", 32'(pending), 32'h0);

    // Masking: pending latches while disabled, request follows enable
    tick(); tick(); tick();
    irq_en = 4'b1101; irq_in = 4'b0010;
    tick(); tick(); tick();
    chk("mask_pend", 32'(pending), 32'h2);
    irq_in = 4'b0000;
    tick(); tick();
    chk("mask_noreq", 32'(irq_req), 32'd0);
    chk("mask_pend_hold", 32'(pending), 32'h2);
    irq_en = 4'b1111;
    tick();
    chk("mask_req", 32'(irq_req), 32'd1);
    chk("mask_id", 32'(irq_id), 32'd1);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("mask_clr", 32'(pending), 32'h0);
    tick(); tick();

    // Overrun and event/ack collision on source 2
    irq_in = 4'b0100;
    tick(); tick(); tick();
    chk("ovr_pend", 32'(pending), 32'h4);
    irq_in = 4'b0000;
    tick();
    chk("ovr_req", 32'(irq_req), 32'd1);
    chk("ovr_id", 32'(irq_id), 32'd2);
    irq_en = 4'b1011;
    tick(); tick();
    irq_in = 4'b0100;
    tick(); tick();
    chk("ovr_flag_early", 32'(overrun), 32'h0);
    tick();
    chk("ovr_flag", 32'(overrun), 32'h4);
    chk("ovr_pend_hold", 32'(pending), 32'h4);
    chk("ovr_req_held", 32'(irq_req), 32'd1);
    chk("ovr_id_held", 32'(irq_id), 32'd2);
    irq_in = 4'b0000; irq_en = 4'b1111;
    tick(); tick(); tick();
    irq_in = 4'b0100;
    tick(); tick();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("coll_pend", 32'(pending), 32'h4);
    chk("coll_drop", 32'(irq_req), 32'd0);
    tick(); tick();
    chk("coll_req2", 32'(irq_req), 32'd1);
    chk("coll_id2", 32'(irq_id), 32'd2);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0; irq_in = 4'b0000;
    chk("coll_clr", 32'(pending), 32'h0);
    chk("coll_ovr_sticky", 32'(overrun), 32'h4);

    // Asynchronous reset in the middle of a request
    tick(); tick(); tick();
    irq_in = 4'b1010;
    tick(); tick(); tick();
    chk("mid_pend", 32'(pending), 32'ha);
    tick();
    chk("mid_req", 32'(irq_req), 32'd1);
    chk("mid_id", 32'(irq_id), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_req", 32'(irq_req), 32'd0);
    chk("mid_rst_pend", 32'(pending), 32'h0);
    chk("mid_rst_ovr", 32'(overrun), 32'h0);
    irq_in = 4'b0000;
    tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    chk("post_rst_req", 32'(irq_req), 32'd0);
    chk("post_rst_pend", 32'(pending), 32'h0);

    // Pulse 0->1->0 with an ack between the edges
    irq_en = 4'b0001; irq_in = 4'b0001;
    tick(); tick(); tick(); tick();
    chk("edge_req1", 32'(irq_req), 32'd1);
    irq_in = 4'b0000;
    req_cnt = 1;
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (irq_req) begin
        req_cnt++;
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
      end else begin
        tick();
      end
    end
`ifdef IRQ_CTRL_BOTH_EDGE_EN
    exp_cnt = 2;
`else
    exp_cnt = 1;
`endif
    chk("edge_count", 32'(req_cnt), 32'(exp_cnt));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
